mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage directly downstream of the delayed-execute stage. It latches one instruction per handshake, passes ALU results straight through, and runs load/store accesses on the SRAM-like data bus. It sign- or zero-extends load data and presents results and forwarding information to the write-back stage and the bypass network. It uses the same valid/allowin interlock as the rest of the pipeline.

## Interface
Parameters: none. Widths come from the shared defines (`GPR_NUM` = 5 bits, `SINGLE_WORD` = 32 bits).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- REEXE_valid_w_i  in  1  upstream has an instruction to hand over this cycle
- REEXE_writeNum_i  in  5  destination GPR; 0 = no write-back
- REEXE_VAddr_i  in  32  instruction PC, for debug and exceptions
- REEXE_regData_i  in  32  ALU result; this is the effective address when memOp ≠ NONE
- REEXE_memOp_i  in  4  memory op code (see package)
- REEXE_storeData_i  in  32  unaligned store source register value
- WB_allowin_w_i  in  1  write-back stage accepts this cycle
- flush_i  in  1  exception/eret flush; kills the held instruction
- MEM_allowin_w_o  out  1  stage can accept upstream this cycle
- MEM_valid_w_o  out  1  hand-over to write-back this cycle
- MEM_forwardMode_w_o  out  1  MEM_regData_o is final and bypassable
- MEM_writeNum_w_o  out  5  destination GPR, for hazard detection
- MEM_writeNum_o / MEM_VAddr_o / MEM_regData_o  out  5/32/32  registered results
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = store
- data_size_o  out  2  0 = byte, 1 = half, 2 = word
- data_addr_o  out  32  byte address
- data_wstrb_o  out  4  byte enables
- data_wdata_o  out  32  store data, replicated to the addressed lanes
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  response; rdata is valid for loads
- data_rdata_i  in  32  load data

## Operation
- **Capture and hold.**
  - Capture from upstream when `REEXE_valid_w_i && MEM_allowin_w_o`.
  - Sets hasData; stores writeNum, VAddr, regData, memOp and storeData.
  - If `!REEXE_valid_w_i && MEM_allowin_w_o`, clear hasData and zero the registers.
- **FSM states.**
  - IDLE: no access pending.
  - REQ: `data_req_o` = 1.
  - WAIT: accepted, awaiting `data_data_ok_i`.
  - DONE: result final.
  - DRAIN: flushed while a response is owed.
- **FSM transitions.**
  - On capture: memOp = NONE → DONE; otherwise → REQ.
  - REQ & addr_ok → WAIT.
  - WAIT & data_ok → DONE. For loads, regData is replaced with the extended load data.
  - DONE & WB_allowin_w_i → IDLE, or REQ/DONE if a new capture occurs in the same cycle.
  - DRAIN & data_ok → IDLE. Response data is discarded.
- **Ready and handshake outputs.**
  - ready = (state == DONE).
  - `MEM_allowin_w_o` = `!hasData || (ready && WB_allowin_w_i)`. It is 0 in DRAIN.
  - `MEM_valid_w_o` = `hasData && ready && WB_allowin_w_i`.
  - `MEM_forwardMode_w_o` = `hasData && ready`.
  - `MEM_writeNum_w_o` = the registered writeNum, driven whenever hasData is set, so decode can stall on a match.
- **Load extension** (a = addr[1:0]):
  - LB / LBU: byte `rdata[8a+7:8a]`, sign- or zero-extended.
  - LH / LHU: half `rdata[16a[1]+15:16a[1]]`, sign- or zero-extended.
  - LW: the full word.
- **Store lanes.**
  - SB: wstrb = 0001 << a; wdata = byte ×4.
  - SH: wstrb = 0011 << a; wdata = half ×2.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
  - A store completes on data_ok, like a load. regData is unchanged.
- **Alignment.** Misaligned addresses are rejected upstream. This stage uses addr[1:0] without checking.
- **Flush.**
  - flush_i clears hasData the next edge, in every state.
  - REQ without addr_ok → IDLE; the request is withdrawn, which the bus allows.
  - REQ with addr_ok, or WAIT → DRAIN, unless data_ok arrives in that same WAIT cycle, which goes to IDLE.
  - flush_i has priority over capture.

## Timing
- **Reset** (rst low at an edge): state IDLE; hasData 0; all registers 0. Every output is 0 except `MEM_allowin_w_o` = 1.
- **Non-memory op:** captured at edge E, valid/bypassable from cycle E+1. Latency 1.
- **Load/store:** `data_req_o` from E+1. With addr_ok at E+1 and data_ok at E+2, the result is valid at E+3.
- **Bus hold:** `data_addr_o`, `data_wr_o`, `data_size_o`, `data_wstrb_o` and `data_wdata_o` are stable while `data_req_o` = 1.
- **Back-to-back:** a DONE hand-over and a new capture in the same cycle give full throughput for non-memory ops.
- **Single outstanding access:** at most one. `data_req_o` is never asserted in WAIT, DRAIN or DONE.

## Structure
- Shared package/defines hold:
  - MEMOP codes: NONE = 0, LB = 1, LBU = 2, LH = 3, LHU = 4, LW = 5, SB = 6, SH = 7, SW = 8.
  - State encodings.
  - Size codes.
- One sub-module, `mem_lane_align`, is purely combinational:
  - Store direction: memOp + addr + storeData → size, wstrb, wdata.
  - Load direction: memOp + addr + rdata → extended result.

## Test plan
- Non-memory op writeNum = 3, regData = 0x1234_5678, WB_allowin held at 1 → `MEM_valid_w_o` one cycle after capture with the same values; `data_req_o` stays 0.
- LB at addr 0x...03, rdata = 0x80FF_0000, addr_ok immediate, data_ok one cycle later → result 0xFFFF_FF80. LBU on the same data → 0x0000_0080.
- SH at addr 0x...02 with storeData = 0xAAAA_BEEF → wstrb = 1100, wdata = 0xBEEF_BEEF, size = 1; `data_req_o` holds across 3 cycles of addr_ok = 0.
- LW completed while WB_allowin = 0 for 4 cycles → stays in DONE; `MEM_forwardMode_w_o` = 1; `MEM_allowin_w_o` = 0; data is stable.
- Flush in WAIT, data_ok 2 cycles later → state DRAIN and `MEM_allowin_w_o` = 0 until data_ok; no `MEM_valid_w_o`; the next instruction is accepted the cycle after.
- rst low during WAIT → all outputs at reset values the next cycle; `MEM_allowin_w_o` = 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the memory-access stage:
//               memory op codes, stage FSM states, bus size codes and
//               op classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int GPR_NUM     = 5;
    localparam int SINGLE_WORD = 32;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LBU  = 4'd2,
        MEMOP_LH   = 4'd3,
        MEMOP_LHU  = 4'd4,
        MEMOP_LW   = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
               (op == MEMOP_LHU) || (op == MEMOP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Purely combinational byte-lane steering for the data bus.
//               Store side: op + addr + store data -> size, wstrb, wdata.
//               Load side : op + addr + bus rdata  -> extended GPR value.
// Ports       : i_mem_op     memory op code
//               i_addr       low two address bits
//               i_store_data store source register
//               i_rdata      bus read data
//               o_size       bus size code
//               o_wstrb      byte enables
//               o_wdata      store data replicated across lanes
//               o_load_data  sign/zero-extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]             i_mem_op,
    input  logic [1:0]             i_addr,
    input  logic [SINGLE_WORD-1:0] i_store_data,
    input  logic [SINGLE_WORD-1:0] i_rdata,
    output logic [1:0]             o_size,
    output logic [3:0]             o_wstrb,
    output logic [SINGLE_WORD-1:0] o_wdata,
    output logic [SINGLE_WORD-1:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Addressed byte / halfword picked out of the returned word.
    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

    always_comb begin
        o_size      = SIZE_WORD;
        o_wstrb     = 4'b0000;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
        case (i_mem_op)
            MEMOP_LB: begin
                o_size      = SIZE_BYTE;
                o_load_data = {{24{w_byte[7]}}, w_byte};
            end
            MEMOP_LBU: begin
                o_size      = SIZE_BYTE;
                o_load_data = {24'd0, w_byte};
            end
            MEMOP_LH: begin
                o_size      = SIZE_HALF;
                o_load_data = {{16{w_half[15]}}, w_half};
            end
            MEMOP_LHU: begin
                o_size      = SIZE_HALF;
                o_load_data = {16'd0, w_half};
            end
            MEMOP_SB: begin
                o_size  = SIZE_BYTE;
                o_wstrb = 4'b0001 << i_addr;
                o_wdata = {4{i_store_data[7:0]}};
            end
            MEMOP_SH: begin
                o_size  = SIZE_HALF;
                o_wstrb = 4'b0011 << i_addr;
                o_wdata = {2{i_store_data[15:0]}};
            end
            MEMOP_SW: begin
                o_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Holds one instruction, passes
//               ALU results through, runs one load/store at a time on the
//               SRAM-like data bus and hands results to write-back using the
//               valid/allowin interlock.
// Ports       : clk, rst (sync, active low)
//               REEXE_*      upstream instruction hand-over
//               WB_allowin   downstream acceptance
//               flush_i      kills the held instruction
//               MEM_*        hand-over, bypass and hazard outputs
//               data_*       data bus request / response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   REEXE_valid_w_i,
    input  logic [GPR_NUM-1:0]     REEXE_writeNum_i,
    input  logic [SINGLE_WORD-1:0] REEXE_VAddr_i,
    input  logic [SINGLE_WORD-1:0] REEXE_regData_i,
    input  logic [3:0]             REEXE_memOp_i,
    input  logic [SINGLE_WORD-1:0] REEXE_storeData_i,
    input  logic                   WB_allowin_w_i,
    input  logic                   flush_i,
    output logic                   MEM_allowin_w_o,
    output logic                   MEM_valid_w_o,
    output logic                   MEM_forwardMode_w_o,
    output logic [GPR_NUM-1:0]     MEM_writeNum_w_o,
    output logic [GPR_NUM-1:0]     MEM_writeNum_o,
    output logic [SINGLE_WORD-1:0] MEM_VAddr_o,
    output logic [SINGLE_WORD-1:0] MEM_regData_o,
    output logic                   data_req_o,
    output logic                   data_wr_o,
    output logic [1:0]             data_size_o,
    output logic [SINGLE_WORD-1:0] data_addr_o,
    output logic [3:0]             data_wstrb_o,
    output logic [SINGLE_WORD-1:0] data_wdata_o,
    input  logic                   data_addr_ok_i,
    input  logic                   data_data_ok_i,
    input  logic [SINGLE_WORD-1:0] data_rdata_i
);

    state_e                 r_state;
    state_e                 w_state_next;
    state_e                 w_capture_state;
    logic                   r_has_data;
    logic [GPR_NUM-1:0]     r_write_num;
    logic [SINGLE_WORD-1:0] r_vaddr;
    logic [SINGLE_WORD-1:0] r_reg_data;
    logic [3:0]             r_mem_op;
    logic [SINGLE_WORD-1:0] r_store_data;

    logic                   w_ready;
    logic                   w_allowin;
    logic                   w_capture;
    logic                   w_req;
    logic [1:0]             w_size;
    logic [3:0]             w_wstrb;
    logic [SINGLE_WORD-1:0] w_wdata;
    logic [SINGLE_WORD-1:0] w_load_data;

    mem_lane_align u_lane_align (
        .i_mem_op     (r_mem_op),
        .i_addr       (r_reg_data[1:0]),
        .i_store_data (r_store_data),
        .i_rdata      (data_rdata_i),
        .o_size       (w_size),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign w_ready = (r_state == ST_DONE);
    // DRAIN holds no instruction but still owes a bus response, so it must
    // block upstream explicitly to keep a single access outstanding.
    assign w_allowin = (r_state != ST_DRAIN) &&
                       (!r_has_data || (w_ready && WB_allowin_w_i));
    // Flush wins over a same-cycle capture.
    assign w_capture = REEXE_valid_w_i && w_allowin && !flush_i;
    assign w_capture_state = (REEXE_memOp_i == MEMOP_NONE) ? ST_DONE : ST_REQ;
    assign w_req = (r_state == ST_REQ);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) w_state_next = w_capture_state;
            end
            ST_REQ: begin
                if (flush_i)             w_state_next = data_addr_ok_i ? ST_DRAIN : ST_IDLE;
                else if (data_addr_ok_i) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_data_ok_i) w_state_next = flush_i ? ST_IDLE : ST_DONE;
                else if (flush_i)   w_state_next = ST_DRAIN;
            end
            ST_DONE: begin
                if (flush_i)             w_state_next = ST_IDLE;
                else if (WB_allowin_w_i) w_state_next = w_capture ? w_capture_state : ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_has_data   <= 1'b0;
            r_write_num  <= '0;
            r_vaddr      <= '0;
            r_reg_data   <= '0;
            r_mem_op     <= MEMOP_NONE;
            r_store_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush_i) begin
                r_has_data   <= 1'b0;
                r_write_num  <= '0;
                r_vaddr      <= '0;
                r_reg_data   <= '0;
                r_mem_op     <= MEMOP_NONE;
                r_store_data <= '0;
            end else if (w_allowin) begin
                // Either take the new instruction or empty the slot.
                r_has_data   <= REEXE_valid_w_i;
                r_write_num  <= REEXE_valid_w_i ? REEXE_writeNum_i  : '0;
                r_vaddr      <= REEXE_valid_w_i ? REEXE_VAddr_i     : '0;
                r_reg_data   <= REEXE_valid_w_i ? REEXE_regData_i   : '0;
                r_mem_op     <= REEXE_valid_w_i ? REEXE_memOp_i     : MEMOP_NONE;
                r_store_data <= REEXE_valid_w_i ? REEXE_storeData_i : '0;
            end else if ((r_state == ST_WAIT) && data_data_ok_i && is_load(r_mem_op)) begin
                // The effective address is no longer needed once the load returns.
                r_reg_data <= w_load_data;
            end
        end
    end

    assign MEM_allowin_w_o     = w_allowin;
    assign MEM_valid_w_o       = r_has_data && w_ready && WB_allowin_w_i;
    assign MEM_forwardMode_w_o = r_has_data && w_ready;
    assign MEM_writeNum_w_o    = r_has_data ? r_write_num : '0;
    assign MEM_writeNum_o      = r_write_num;
    assign MEM_VAddr_o         = r_vaddr;
    assign MEM_regData_o       = r_reg_data;

    // Bus fields come from held registers, so they are stable while requesting.
    assign data_req_o   = w_req;
    assign data_wr_o    = w_req && is_store(r_mem_op);
    assign data_size_o  = w_req ? w_size     : 2'b00;
    assign data_addr_o  = w_req ? r_reg_data : '0;
    assign data_wstrb_o = w_req ? w_wstrb    : 4'b0000;
    assign data_wdata_o = w_req ? w_wdata    : '0;

endmodule
`default_nettype wire
